// File: rtl/msi_pkg.sv
// rtl/msi_pkg.sv - shared MSI bus encodings used by caches and the bus controller
//
// Purpose: bus message and cache-state encodings, shared by the cache
// controllers and msi_bus_ctrl, plus the controller FSM state type.
// Ports: none (package).
package msi_pkg;

  localparam int MSG_W = 3;

  localparam logic [MSG_W-1:0] BUS_IDLE  = 3'd0;
  localparam logic [MSG_W-1:0] BUS_RD    = 3'd1;
  localparam logic [MSG_W-1:0] BUS_RDX   = 3'd2;
  localparam logic [MSG_W-1:0] BUS_UPGR  = 3'd3;
  localparam logic [MSG_W-1:0] BUS_FLUSH = 3'd4;

  localparam logic [1:0] CACHE_I = 2'd0;
  localparam logic [1:0] CACHE_S = 2'd1;
  localparam logic [1:0] CACHE_M = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SNOOP,
    ST_MEMWAIT,
    ST_DATA
  } bus_state_e;

  // Only RD, RDX and UPGR may be requested by a cache; FLUSH is a snoop reply.
  function automatic logic is_req_msg(input logic [MSG_W-1:0] msg);
    return (msg == BUS_RD) || (msg == BUS_RDX) || (msg == BUS_UPGR);
  endfunction

endpackage

// File: rtl/msi_bus_ctrl_if.sv
// rtl/msi_bus_ctrl_if.sv - bundle of all cache-to-bus-controller signals
//
// Purpose: groups the request, broadcast, flush and data-return signals.
// Modports:
//   master - cache side: drives bus_req_i, req_msg_i, req_addr_i, flush_i
//   slave  - bus controller: drives gnt_o, bus_msg_o, bus_addr_o,
//            bus_owner_o, data_valid_o, data_dst_o, err_o
interface msi_bus_ctrl_if #(
  parameter int NUM_CPUS = 2,
  parameter int ADDR_W   = 2
);
  import msi_pkg::*;

  logic [NUM_CPUS-1:0]        bus_req_i;
  logic [MSG_W*NUM_CPUS-1:0]  req_msg_i;
  logic [ADDR_W*NUM_CPUS-1:0] req_addr_i;
  logic [NUM_CPUS-1:0]        flush_i;
  logic [NUM_CPUS-1:0]        gnt_o;
  logic [MSG_W-1:0]           bus_msg_o;
  logic [ADDR_W-1:0]          bus_addr_o;
  logic [NUM_CPUS-1:0]        bus_owner_o;
  logic                       data_valid_o;
  logic [NUM_CPUS-1:0]        data_dst_o;
  logic                       err_o;

  modport master (
    output bus_req_i, req_msg_i, req_addr_i, flush_i,
    input  gnt_o, bus_msg_o, bus_addr_o, bus_owner_o, data_valid_o, data_dst_o, err_o
  );

  modport slave (
    input  bus_req_i, req_msg_i, req_addr_i, flush_i,
    output gnt_o, bus_msg_o, bus_addr_o, bus_owner_o, data_valid_o, data_dst_o, err_o
  );

endinterface

// File: rtl/msi_bus_ctrl_rr_arbiter.sv
// rtl/msi_bus_ctrl_rr_arbiter.sv - round-robin arbiter with priority pointer
//
// Purpose: picks one requester starting at the pointer; the pointer moves
// past the accepted winner so every held request is eventually served.
// Ports:
//   clk_i, rst_i - clock, async active-high reset (pointer -> CPU0)
//   req_i        - per-CPU request vector
//   accept_i     - winner in won_i was accepted this cycle
//   won_i        - one-hot accepted winner
//   gnt_o        - one-hot combinational pick (0 when no request)
module rr_arbiter #(
  parameter int NUM_CPUS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_CPUS-1:0] req_i,
  input  logic                accept_i,
  input  logic [NUM_CPUS-1:0] won_i,
  output logic [NUM_CPUS-1:0] gnt_o
);

  localparam int PTR_W = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [2*NUM_CPUS-1:0] req2;
  logic [NUM_CPUS-1:0]   rot, pick;
  logic [2*NUM_CPUS-1:0] spread;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign req2 = {req_i, req_i};

  // Rotate so the pointer CPU sits at bit 0, take the lowest set bit,
  // then rotate the one-hot pick back into CPU numbering.
  always_comb begin
    rot  = NUM_CPUS'(req2 >> ptr_q);
    pick = '0;
    for (int i = NUM_CPUS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
    spread = {{NUM_CPUS{1'b0}}, pick} << ptr_q;
    gnt_o  = spread[NUM_CPUS-1:0] | spread[2*NUM_CPUS-1:NUM_CPUS];
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) begin
      for (int i = 0; i < NUM_CPUS; i++) begin
        if (won_i[i]) ptr_d = (i == NUM_CPUS - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/msi_bus_ctrl.sv
// rtl/msi_bus_ctrl.sv - snoopy bus controller for MSI cache controllers
//
// Purpose: arbitrates cache bus requests round-robin, broadcasts the winning
// message/address for one snoop cycle, then returns data either from a
// flushing cache (next cycle) or after MEM_LAT cycles of memory latency.
// Ports:
//   clk_i - clock
//   rst_i - asynchronous active-high reset
//   bus   - msi_bus_ctrl_if.slave: requests/flush in; grant, broadcast,
//           data-return and error pulse out
module msi_bus_ctrl
  import msi_pkg::*;
#(
  parameter int NUM_CPUS = 2,
  parameter int ADDR_W   = 2,
  parameter int MEM_LAT  = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  msi_bus_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_LAT) + 1;

  bus_state_e          state_q, state_d;
  logic [MSG_W-1:0]    msg_q, msg_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_CPUS-1:0] owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CPUS-1:0] arb_gnt;
  logic                flush_hit;

  rr_arbiter #(.NUM_CPUS(NUM_CPUS)) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (bus.bus_req_i),
    .accept_i (state_q == ST_GRANT),
    .won_i    (owner_q),
    .gnt_o    (arb_gnt)
  );

  // The owner may report a flush of its own line; only other caches count.
  assign flush_hit = |(bus.flush_i & ~owner_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      msg_q   <= BUS_IDLE;
      addr_q  <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      addr_q  <= addr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    addr_d  = addr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.bus_req_i) begin
          owner_d = arb_gnt;
          for (int i = 0; i < NUM_CPUS; i++) begin
            if (arb_gnt[i]) begin
              msg_d  = bus.req_msg_i[MSG_W*i +: MSG_W];
              addr_d = bus.req_addr_i[ADDR_W*i +: ADDR_W];
            end
          end
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: state_d = is_req_msg(msg_q) ? ST_SNOOP : ST_IDLE;
      ST_SNOOP: begin
        if (msg_q == BUS_UPGR) begin
          state_d = ST_IDLE;
        end else if (flush_hit) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_MEMWAIT;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end
      end
      ST_MEMWAIT: begin
        if (cnt_q == '0) state_d = ST_DATA;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DATA: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt_o        = '0;
    bus.err_o        = 1'b0;
    bus.bus_msg_o    = BUS_IDLE;
    bus.bus_addr_o   = '0;
    bus.bus_owner_o  = '0;
    bus.data_valid_o = 1'b0;
    bus.data_dst_o   = '0;
    unique case (state_q)
      ST_GRANT: begin
        bus.gnt_o = owner_q;
        bus.err_o = ~is_req_msg(msg_q);
      end
      ST_SNOOP: begin
        bus.bus_msg_o   = msg_q;
        bus.bus_addr_o  = addr_q;
        bus.bus_owner_o = owner_q;
      end
      ST_DATA: begin
        bus.data_valid_o = 1'b1;
        bus.data_dst_o   = owner_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/msi_bus_ctrl.md
Name: msi_bus_ctrl

Overview:
- Snoopy-bus controller that sits directly downstream of the per-CPU MSI cache controllers.
- Arbitrates their bus requests round-robin and broadcasts the winning message and address to every cache for one snoop cycle.
- Collects flush responses, models memory latency, and returns data_valid to the requester.
- One instance per system; all cache bus ports connect here.

Parameters:
- NUM_CPUS, 2, number of cache controllers attached (≥2).
- ADDR_W, 2, line address width.
- MEM_LAT, 4, cycles from snoop to data when no cache flushes (≥1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- bus_req_i  in  NUM_CPUS  per-CPU bus request, held until granted.
- req_msg_i  in  3*NUM_CPUS  per-CPU message, slice i = [3i+2:3i].
- req_addr_i  in  ADDR_W*NUM_CPUS  per-CPU line address.
- gnt_o  out  NUM_CPUS  one-hot grant, one-cycle pulse.
- bus_msg_o  out  3  broadcast message (IDLE=0, RD=1, RDX=2, UPGR=3, FLUSH=4).
- bus_addr_o  out  ADDR_W  broadcast address.
- bus_owner_o  out  NUM_CPUS  one-hot owner of the current transaction.
- flush_i  in  NUM_CPUS  per-CPU flush response during snoop.
- data_valid_o  out  1  data-return pulse.
- data_dst_o  out  NUM_CPUS  one-hot destination, valid with data_valid_o.
- err_o  out  1  one-cycle pulse on an illegal request message.

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0; bus_msg_o=IDLE; round-robin pointer = CPU0 highest priority.
- States: IDLE, GRANT, SNOOP, MEMWAIT, DATA.
- IDLE:
  - If any bus_req_i is high, pick the winner round-robin starting at the pointer.
  - Register the winner's msg/addr and owner.
  - Go to GRANT.
- GRANT (1 cycle):
  - gnt_o = owner.
  - Pointer ← winner+1, wrapping NUM_CPUS-1→0.
  - The cache drops bus_req_i the cycle after gnt_o.
- Illegal message in GRANT (msg IDLE, FLUSH, or >4): err_o pulses in GRANT; return to IDLE with no broadcast.
- SNOOP (exactly 1 cycle): bus_msg_o, bus_addr_o and bus_owner_o are driven; all other cycles drive IDLE, 0 and 0.
- Flush sampling in SNOOP:
  - flush_i is sampled from non-owner CPUs only; the owner's bit is ignored.
  - UPGR → IDLE (no data phase).
  - RD/RDX with any non-owner flush → DATA.
  - Otherwise → MEMWAIT with counter = MEM_LAT-1.
- MEMWAIT: decrement each cycle; at 0 → DATA. Total SNOOP-to-data_valid = MEM_LAT+1 cycles.
- DATA (1 cycle): data_valid_o=1, data_dst_o=owner; then IDLE.
- Flush path latency: SNOOP-to-data_valid = 1 cycle.
- Back-to-back: new arbitration only from IDLE, so the minimum transaction is 4 cycles (IDLE, GRANT, SNOOP, DATA), or 3 for UPGR.
- Requests arriving mid-transaction wait; they are never lost while held.
- Simultaneous requests: exactly one grant; the losers keep requesting and win in pointer order.
- A single requester re-requesting repeatedly is always granted (pointer skips idle CPUs).
- Reset asserted mid-transaction aborts immediately: outputs 0, no data_valid, pointer reset.
- Counter width = clog2(MEM_LAT)+1; no wrap beyond MEM_LAT.

Decomposition:
- Shared package msi_pkg:
  - Bus message constants (BUS_IDLE..BUS_FLUSH).
  - Message width 3.
  - Cache-state constants, so the cache controller and this block agree on encodings.
- One sub-module: rr_arbiter (NUM_CPUS).
  - Inputs: req, pointer. Output: one-hot grant.
  - Combinational, with pointer register update on accept.

Test Plan:
- Reset, then CPU0 RD addr 1, no flush, MEM_LAT=4 → gnt_o=01 at cycle 1; SNOOP bus_msg_o=1, bus_addr_o=1 at cycle 2; data_valid_o with data_dst_o=01 at cycle 7.
- CPU1 RDX addr 2, CPU0 flush_i=1 in SNOOP → data_valid_o with data_dst_o=10 one cycle after SNOOP; no MEMWAIT.
- CPU0 UPGR addr 3 → SNOOP broadcast of msg 3; back in IDLE next cycle; data_valid_o never asserted.
- CPU0 and CPU1 both request from reset → grant order 01, 10, 01 across three transactions while both hold their requests.
- CPU1 req_msg=4 (FLUSH) → err_o pulse in GRANT; bus_msg_o stays 0; IDLE next cycle.
- Assert rst_i during MEMWAIT → all outputs 0 immediately; no data_valid_o after release; next grant goes to CPU0.
